fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch control sequencer sitting directly upstream of the program counter. Generates the PC control strobes (increment, drive onto the address bus, load from the address bus). Runs a read handshake with memory to capture the opcode and up to two operand bytes from `db`. Hands each decoded instruction to the execute unit through a start/done handshake and applies jump targets back into the PC.

## Interface
- `HALT_OP`, default 8'hFF: opcode that enters HALT.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `db`  in  8  data bus; sampled when `mem_rd` and `mem_ack` are both high.
- `mem_ack`  in  1  memory read acknowledge; any number of wait cycles allowed.
- `exec_done`  in  1  execute unit has finished the current instruction.
- `exec_jump`  in  1  qualifies `exec_done`: a jump is taken to {`opr_hi`,`opr_lo`}.
- `mem_rd`  out  1  memory read request.
- `pci`  out  1  PC increment strobe.
- `pcl_abl`, `pch_abh`  out  1 each  PC low/high byte drives ABL/ABH.
- `abl_pcl`, `abh_pch`  out  1 each  PC low/high byte loads from ABL/ABH.
- `opr_ab_oe`  out  1  top level drives ABL=`opr_lo`, ABH=`opr_hi`.
- `ir`  out  8  instruction register.
- `opr_lo`, `opr_hi`  out  8 each  operand registers.
- `exec_start`  out  1  one-cycle pulse: `ir`/`opr_*` valid, start execution.
- `halted`  out  1  sequencer is in HALT.

## Operation
- States: IDLE, FETCH_OP, FETCH_OPR1, FETCH_OPR2, EXEC_START, EXEC_WAIT, JUMP, HALT.
- **Reset.** While `rst`=0, the state is forced to IDLE, and `ir`, `opr_lo` and `opr_hi` are cleared to 8'h00.
  - All outputs are 0 in IDLE.
  - IDLE → FETCH_OP on the first edge with `rst`=1.
- **Fetch states** (FETCH_OP, FETCH_OPR1, FETCH_OPR2):
  - `mem_rd`=`pcl_abl`=`pch_abh`=1.
  - `pci` = `mem_ack` (combinational), so the PC increments on the same edge that captures the byte.
  - The state is held while `mem_ack`=0.
- **Operand count** is taken from the captured opcode bits [7:6]: 00 → 0 operands, 01 → 1 operand, 10 or 11 → 2 operands.
- **FETCH_OP + ack:**
  - `ir` ← `db`.
  - If `db`==HALT_OP → HALT.
  - Otherwise → FETCH_OPR1 if the count ≥1, else EXEC_START.
- **FETCH_OPR1 + ack:** `opr_lo` ← `db`; → FETCH_OPR2 if the count is 2, else EXEC_START.
- **FETCH_OPR2 + ack:** `opr_hi` ← `db`; → EXEC_START.
- **Operand register retention:**
  - 0-operand instructions leave `opr_lo` and `opr_hi` unchanged.
  - 1-operand instructions leave `opr_hi` unchanged.
- **EXEC_START:** `exec_start`=1 for exactly this cycle. `exec_done` is honoured in this same cycle.
- **EXEC_START / EXEC_WAIT exits:**
  - `exec_done`=1, `exec_jump`=0 → FETCH_OP.
  - `exec_done`=1, `exec_jump`=1 → JUMP.
  - `exec_done`=0: EXEC_START → EXEC_WAIT, or EXEC_WAIT holds.
- `exec_jump` is ignored when `exec_done`=0.
- **JUMP** (exactly one cycle): `opr_ab_oe`=`abl_pcl`=`abh_pch`=1 and `pci`=0. → FETCH_OP.
- **HALT:** `halted`=1, all other strobes 0, `exec_start` never pulses. Only reset exits.
- **Strobe exclusivity:**
  - `pcl_abl`/`pch_abh` and `abl_pcl`/`abh_pch` are never high together.
  - `pci` is never high outside the fetch states.
- `db` and `exec_*` inputs are ignored in states where they are not listed.

## Timing
- Outputs are a function of the current state plus `mem_ack`. Registers update on the rising edge.
- **Zero-wait instruction fetch:** 1 cycle per byte.
  - 0-operand opcode: FETCH_OP at cycle n, EXEC_START at n+1.
  - 2-operand opcode: EXEC_START at n+3.
- **Instruction period:** with zero-wait memory and `exec_done` in the EXEC_START cycle, a 0-operand instruction takes 2 cycles. A jump adds 1 cycle.
- **Wait states:** each cycle with `mem_ack`=0 adds one cycle. `pci` stays 0 during waits.
- **Reset mid-operation** (during a fetch wait or EXEC_WAIT):
  - Takes effect on the next edge: IDLE, `mem_rd`=0, registers cleared.
  - No `pci` or `exec_start` is emitted on that edge.
  - A `mem_ack` on the reset edge is ignored.
- After `rst` rises, `mem_rd` is first asserted 1 cycle later (IDLE cycle).

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `mem_ack`=1 and `db`=8'hA5 → all outputs 0 and `ir`=8'h00. One cycle after release, `mem_rd`=1.
- **Zero-wait fetch:** memory returns 8'h85, 8'h34, 8'h12 with `mem_ack`=1 and `exec_done` held 1 → results:
  - `ir`=8'h85, `opr_lo`=8'h34, `opr_hi`=8'h12.
  - `pci` high exactly 3 cycles.
  - `exec_start` is a single pulse on the 4th cycle after IDLE.
- **Wait states:** opcode 8'h41 with `mem_ack` low 2 cycles on each byte → results:
  - `pci` high only on the ack cycles.
  - `opr_lo` is captured and `opr_hi` is unchanged.
  - `exec_start` arrives 6 cycles after FETCH_OP entry.
- **Jump:** opcode 8'h80, 8'h00, 8'hC0, then `exec_done`=`exec_jump`=1 → one cycle with `opr_ab_oe`=`abl_pcl`=`abh_pch`=1 and `pci`=0, followed by FETCH_OP.
- **Halt:** opcode 8'hFF → `halted`=1 from the next cycle. `mem_rd`, `pci` and `exec_start` stay 0 for 10 cycles. After reset, fetch resumes.
- **Reset mid-wait:** assert `rst`=0 in FETCH_OPR1 during a wait, with `mem_ack`=1 on the same edge → `opr_lo`=8'h00, no `pci` pulse, IDLE next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control sequencer: drives PC strobes, runs the memory read
// handshake for opcode/operands and hands instructions to the execute unit.
module fetch_sequencer #(
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] db,
    input  logic       mem_ack,
    input  logic       exec_done,
    input  logic       exec_jump,
    output logic       mem_rd,
    output logic       pci,
    output logic       pcl_abl,
    output logic       pch_abh,
    output logic       abl_pcl,
    output logic       abh_pch,
    output logic       opr_ab_oe,
    output logic [7:0] ir,
    output logic [7:0] opr_lo,
    output logic [7:0] opr_hi,
    output logic       exec_start,
    output logic       halted
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_OP   = 3'd1,
        ST_FETCH_OPR1 = 3'd2,
        ST_FETCH_OPR2 = 3'd3,
        ST_EXEC_START = 3'd4,
        ST_EXEC_WAIT  = 3'd5,
        ST_JUMP       = 3'd6,
        ST_HALT       = 3'd7
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] ir_r;
    logic [7:0] opr_lo_r;
    logic [7:0] opr_hi_r;
    logic       fetch_r;
    logic       jump_r;
    logic       exec_start_r;
    logic       halted_r;

    // Operand bytes that follow an opcode, from its top two bits.
    function automatic logic [1:0] opr_count(input logic [7:0] op);
        logic [1:0] cnt;
        case (op[7:6])
            2'b00:   cnt = 2'd0;
            2'b01:   cnt = 2'd1;
            default: cnt = 2'd2;
        endcase
        return cnt;
    endfunction

    // Next-state decode from the current state and handshake inputs.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = ST_FETCH_OP;
            ST_FETCH_OP: begin
                if (!mem_ack) begin
                    state_next_s = ST_FETCH_OP;
                end else if (db == HALT_OP) begin
                    state_next_s = ST_HALT;
                end else if (opr_count(db) != 2'd0) begin
                    state_next_s = ST_FETCH_OPR1;
                end else begin
                    state_next_s = ST_EXEC_START;
                end
            end
            ST_FETCH_OPR1: begin
                if (!mem_ack) begin
                    state_next_s = ST_FETCH_OPR1;
                end else if (opr_count(ir_r) == 2'd2) begin
                    state_next_s = ST_FETCH_OPR2;
                end else begin
                    state_next_s = ST_EXEC_START;
                end
            end
            ST_FETCH_OPR2: begin
                if (mem_ack) begin
                    state_next_s = ST_EXEC_START;
                end else begin
                    state_next_s = ST_FETCH_OPR2;
                end
            end
            ST_EXEC_START, ST_EXEC_WAIT: begin
                if (!exec_done) begin
                    state_next_s = ST_EXEC_WAIT;
                end else if (exec_jump) begin
                    state_next_s = ST_JUMP;
                end else begin
                    state_next_s = ST_FETCH_OP;
                end
            end
            ST_JUMP: state_next_s = ST_FETCH_OP;
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, captured bytes and state-decoded strobes, all registered together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            ir_r         <= 8'h00;
            opr_lo_r     <= 8'h00;
            opr_hi_r     <= 8'h00;
            fetch_r      <= 1'b0;
            jump_r       <= 1'b0;
            exec_start_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            fetch_r      <= (state_next_s == ST_FETCH_OP) ||
                            (state_next_s == ST_FETCH_OPR1) ||
                            (state_next_s == ST_FETCH_OPR2);
            jump_r       <= (state_next_s == ST_JUMP);
            exec_start_r <= (state_next_s == ST_EXEC_START);
            halted_r     <= (state_next_s == ST_HALT);
            case (state_r)
                ST_FETCH_OP:   ir_r     <= mem_ack ? db : ir_r;
                ST_FETCH_OPR1: opr_lo_r <= mem_ack ? db : opr_lo_r;
                ST_FETCH_OPR2: opr_hi_r <= mem_ack ? db : opr_hi_r;
                default: begin
                    ir_r     <= ir_r;
                    opr_lo_r <= opr_lo_r;
                    opr_hi_r <= opr_hi_r;
                end
            endcase
        end
    end

    // pci is gated by rst so a reset edge never also advances the PC.
    assign pci        = fetch_r & mem_ack & rst;
    assign mem_rd     = fetch_r;
    assign pcl_abl    = fetch_r;
    assign pch_abh    = fetch_r;
    assign abl_pcl    = jump_r;
    assign abh_pch    = jump_r;
    assign opr_ab_oe  = jump_r;
    assign exec_start = exec_start_r;
    assign halted     = halted_r;
    assign ir         = ir_r;
    assign opr_lo     = opr_lo_r;
    assign opr_hi     = opr_hi_r;

endmodule
